uart_imem_loader: RTL and testbench

- Receive-side instruction loader for the Arty SoC. While load_imem is high, it deserializes 8N1 bytes arriving on uart0_rxd, packs them little-endian into 32-bit words, and writes the words sequentially into instruction RAM from word address 0.
- It is the hardware counterpart of the bench's backdoor imem preload: a host transmits the instr_ram.rom byte stream and this block writes it in.

---
 rtl/uart_imem_loader_pkg.sv | 15 +
 rtl/uart_rx_core.sv | 118 +++++++++++
 rtl/uart_imem_loader.sv | 105 ++++++++++
 tb/tb_uart_imem_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package uart_imem_loader_pkg;

  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned SYNC_STAGES    = 2;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchronizer, baud counter and RX FSM.
// Emits one-cycle rx_valid / rx_frame_err pulses per completed frame.
module uart_rx_core
  import uart_imem_loader_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       abort,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2 - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rxd_s;
  logic                   rxd_q;
  rx_state_e              state;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   err_wait;

  assign rxd_s = sync[SYNC_STAGES-1];

  // Receiver state machine; rxd_q tracks the previous synced level for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync         <= '1;
      rxd_q        <= 1'b1;
      state        <= RX_IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      err_wait     <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      sync         <= {sync[SYNC_STAGES-2:0], rxd};
      rxd_q        <= rxd_s;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      if (abort) begin
        state    <= RX_IDLE;
        rx_busy  <= 1'b0;
        err_wait <= 1'b0;
      end else begin
        case (state)
          RX_IDLE: begin
            if (enable && rxd_q && !rxd_s) begin
              state   <= RX_START;
              cnt     <= HALF_BIT;
              rx_busy <= 1'b1;
            end
          end
          RX_START: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else if (!rxd_s) begin
              state   <= RX_DATA;
              cnt     <= FULL_BIT;
              bit_cnt <= '0;
            end else begin
              state   <= RX_IDLE;
              rx_busy <= 1'b0;
            end
          end
          RX_DATA: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else begin
              shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
              cnt     <= FULL_BIT;
              bit_cnt <= bit_cnt + BW'(1);
              if (bit_cnt == BW'(DATA_BITS - 1)) state <= RX_STOP;
            end
          end
          RX_STOP: begin
            // After a framing error, hold here until the line returns to idle.
            if (err_wait) begin
              if (rxd_s) begin
                state    <= RX_IDLE;
                rx_busy  <= 1'b0;
                err_wait <= 1'b0;
              end
            end else if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else if (rxd_s) begin
              rx_valid <= 1'b1;
              rx_data  <= shreg;
              state    <= RX_IDLE;
              rx_busy  <= 1'b0;
            end else begin
              rx_frame_err <= 1'b1;
              err_wait     <= 1'b1;
            end
          end
          default: begin
            state   <= RX_IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_imem_loader.sv
// Loads instruction RAM from a UART byte stream, packing bytes little-endian into words.
// Define UART_IMEM_LOADER_CHECKSUM_EN to build the running word-sum checksum.
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 868,
  parameter int unsigned IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_imem,
  input  logic               uart_rxd,
  output logic               imem_wr,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               busy,
  output logic [IMEM_AW:0]   words_written,
  output logic               frame_err,
  output logic [31:0]        checksum
);

  localparam int unsigned WW = IMEM_AW + 1;
  localparam int unsigned IW = $clog2(BYTES_PER_WORD);

  logic          load_q;
  logic          load_rise;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_frame_err;
  logic [IW-1:0] byte_idx;
  logic [23:0]   word_buf;

  assign load_rise = load_imem & ~load_q;

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk          (clk),
    .reset        (reset),
    .enable       (load_imem),
    .abort        (load_rise),
    .rxd          (uart_rxd),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (busy)
  );

  // Session control, byte packing and write sequencing; a load rising edge overrides all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_q        <= 1'b0;
      imem_wr       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      words_written <= '0;
      frame_err     <= 1'b0;
      byte_idx      <= '0;
      word_buf      <= '0;
    end else begin
      load_q  <= load_imem;
      imem_wr <= 1'b0;
      if (load_rise) begin
        imem_addr     <= '0;
        words_written <= '0;
        frame_err     <= 1'b0;
        byte_idx      <= '0;
      end else begin
        if (imem_wr) begin
          imem_addr <= imem_addr + IMEM_AW'(1);
          if (!words_written[IMEM_AW]) words_written <= words_written + WW'(1);
        end
        if (load_imem && rx_frame_err) frame_err <= 1'b1;
        if (load_imem && rx_valid) begin
          if (byte_idx == IW'(BYTES_PER_WORD - 1)) begin
            imem_wdata <= {rx_data, word_buf};
            imem_wr    <= 1'b1;
            byte_idx   <= '0;
          end else begin
            case (byte_idx)
              IW'(0):  word_buf[7:0]   <= rx_data;
              IW'(1):  word_buf[15:8]  <= rx_data;
              default: word_buf[23:16] <= rx_data;
            endcase
            byte_idx <= byte_idx + IW'(1);
          end
        end
      end
    end
  end

`ifdef UART_IMEM_LOADER_CHECKSUM_EN
  // Running mod-2^32 sum of every word written this session.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else if (load_rise) begin
      checksum <= '0;
    end else if (imem_wr) begin
      checksum <= checksum + imem_wdata;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: directed cases plus randomized byte stream
// against a byte/word-level model; honours UART_IMEM_LOADER_CHECKSUM_EN.
module tb_uart_imem_loader;

  localparam int unsigned BAUD = 16;
  localparam int unsigned AW   = 3;
  localparam int          NWORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_imem;
  logic          uart_rxd;
  logic          imem_wr;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic [AW:0]   words_written;
  logic          frame_err;
  logic [31:0]   checksum;

  uart_imem_loader #(.BAUD_DIV(BAUD), .IMEM_AW(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .load_imem     (load_imem),
    .uart_rxd      (uart_rxd),
    .imem_wr       (imem_wr),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .busy          (busy),
    .words_written (words_written),
    .frame_err     (frame_err),
    .checksum      (checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  wr_t         exp_q[$];
  int          m_addr, m_words, m_idx;
  logic        m_err;
  logic [31:0] m_sum;
  logic [7:0]  m_buf[4];
  int          wr_count = 0;
  logic [31:0] last_data = '0;
  logic [31:0] last_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] exp_checksum();
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
    return m_sum;
`else
    return 32'h0;
`endif
  endfunction

  function automatic void model_clear();
    m_addr  = 0;
    m_words = 0;
    m_idx   = 0;
    m_err   = 1'b0;
    m_sum   = '0;
  endfunction

  // Model: what one frame does to the session, given the enable level during it.
  function automatic void model_byte(input logic [7:0] b, input bit stop_ok, input logic en);
    wr_t w;
    if (!en) return;
    if (!stop_ok) begin
      m_err = 1'b1;
      return;
    end
    m_buf[m_idx] = b;
    m_idx++;
    if (m_idx == 4) begin
      w.addr = 32'(m_addr);
      w.data = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
      exp_q.push_back(w);
      m_sum   = m_sum + w.data;
      m_addr  = (m_addr + 1) % NWORDS;
      m_words = (m_words < NWORDS) ? m_words + 1 : NWORDS;
      m_idx   = 0;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok, load_imem);
    uart_rxd = 1'b0;
    wait_cyc(BAUD);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_cyc(BAUD);
    end
    uart_rxd = stop_ok;
    wait_cyc(BAUD);
    uart_rxd = 1'b1;
    wait_cyc(6);
  endtask

  task automatic raise_load();
    load_imem = 1'b0;
    wait_cyc(3);
    load_imem = 1'b1;
    model_clear();
    wait_cyc(3);
  endtask

  task automatic check_quiet(input string tag);
    wait_cyc(4);
    chk({tag, " pending writes"}, 32'(exp_q.size()), 32'd0);
    chk({tag, " imem_addr"}, 32'(imem_addr), 32'(m_addr));
    chk({tag, " words_written"}, 32'(words_written), 32'(m_words));
    chk({tag, " frame_err"}, 32'(frame_err), 32'(m_err));
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " checksum"}, checksum, exp_checksum());
  endtask

  // Every write strobe must match the next word the model expects.
  always @(negedge clk) begin
    if (reset && imem_wr) begin
      wr_t e;
      wr_count++;
      last_data = imem_wdata;
      last_addr = 32'(imem_addr);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected write: addr 0x%0h data 0x%0h, expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write addr", 32'(imem_addr), e.addr);
        chk("write data", imem_wdata, e.data);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [7:0] b;
    reset     = 1'b0;
    load_imem = 1'b0;
    uart_rxd  = 1'b1;
    model_clear();
    wait_cyc(5);
    chk("reset imem_wr", 32'(imem_wr), 32'd0);
    chk("reset words_written", 32'(words_written), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    reset = 1'b1;
    wait_cyc(3);

    // Single word
    raise_load();
    n0 = wr_count;
    send_byte(8'h13, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
    check_quiet("one word");
    chk("one word count", 32'(wr_count - n0), 32'd1);
    chk("one word data", last_data, 32'h0000_0013);
    chk("one word addr", last_addr, 32'd0);

    // Two words and checksum
    raise_load();
    foreach (m_buf[i]) m_buf[i] = '0;
    send_byte(8'h97, 1); send_byte(8'h01, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
    send_byte(8'h93, 1); send_byte(8'h81, 1); send_byte(8'h81, 1); send_byte(8'h80, 1);
    check_quiet("two words");
    chk("two words last data", last_data, 32'h8081_8193);
    chk("two words last addr", last_addr, 32'd1);
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
    chk("two words checksum literal", checksum, 32'h8081_832A);
`else
    chk("two words checksum literal", checksum, 32'h0);
`endif

    // Framing error, then a clean word
    raise_load();
    send_byte(8'h55, 0);
    check_quiet("stop error");
    chk("stop error literal", 32'(frame_err), 32'd1);
    send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1); send_byte(8'h04, 1);
    check_quiet("after error");
    chk("after error data", last_data, 32'h0403_0201);
    chk("after error addr", last_addr, 32'd0);
    raise_load();
    check_quiet("error cleared");
    chk("error cleared literal", 32'(frame_err), 32'd0);

    // Partial word discarded across a load drop
    n0 = wr_count;
    send_byte(8'h11, 1); send_byte(8'h22, 1);
    load_imem = 1'b0;
    wait_cyc(3);
    send_byte(8'h33, 1); send_byte(8'h44, 1);
    check_quiet("load low");
    raise_load();
    send_byte(8'hA1, 1); send_byte(8'hB2, 1); send_byte(8'hC3, 1); send_byte(8'hD4, 1);
    check_quiet("reload");
    chk("reload count", 32'(wr_count - n0), 32'd1);
    chk("reload data", last_data, 32'hD4C3_B2A1);
    chk("reload addr", last_addr, 32'd0);

    // One-cycle glitch while idle
    raise_load();
    n0 = wr_count;
    uart_rxd = 1'b0;
    wait_cyc(1);
    uart_rxd = 1'b1;
    wait_cyc(BAUD);
    check_quiet("glitch");
    chk("glitch count", 32'(wr_count - n0), 32'd0);

    // Asynchronous reset in the middle of byte 3's data bits
    raise_load();
    send_byte(8'h5A, 1); send_byte(8'hA5, 1);
    uart_rxd = 1'b0;
    wait_cyc(BAUD);
    uart_rxd = 1'b1;
    wait_cyc(3 * BAUD);
    reset = 1'b0;
    model_clear();
    exp_q.delete();
    wait_cyc(2);
    chk("mid reset imem_wr", 32'(imem_wr), 32'd0);
    chk("mid reset imem_addr", 32'(imem_addr), 32'd0);
    chk("mid reset imem_wdata", imem_wdata, 32'd0);
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset words_written", 32'(words_written), 32'd0);
    chk("mid reset frame_err", 32'(frame_err), 32'd0);
    chk("mid reset checksum", checksum, 32'd0);
    wait_cyc(2 * BAUD);
    reset = 1'b1;
    wait_cyc(5);
    send_byte(8'h21, 1); send_byte(8'h43, 1); send_byte(8'h65, 1); send_byte(8'h87, 1);
    check_quiet("after reset");
    chk("after reset data", last_data, 32'h8765_4321);
    chk("after reset addr", last_addr, 32'd0);

    // Address wrap and counter saturation over nine words
    raise_load();
    for (int i = 0; i < 36; i++) send_byte(8'($urandom), 1);
    check_quiet("wrap");
    chk("wrap words_written literal", 32'(words_written), 32'd8);
    chk("wrap imem_addr literal", 32'(imem_addr), 32'd1);

    // Randomized stream with occasional bad stop bits and load toggles
    raise_load();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if (load_imem) begin
          load_imem = 1'b0;
          wait_cyc(3);
        end else begin
          raise_load();
        end
      end
      b = 8'($urandom);
      send_byte(b, $urandom_range(0, 7) != 0);
    end
    check_quiet("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
